exp3_fluxo_dados: RTL and testbench

Datapath of the memory-sequence game unit. Holds four pieces:
- a 4-bit address counter;
- a 4-bit play register that captures the switch value;
- a 16x4 ROM of expected plays, addressed by the counter;
- an equality comparator between the register and the ROM word.

The block is driven by the game's control unit (zeraC, contaC, zeraR, registraR) and returns status signals (igual, fimC) plus debug buses.

---
 rtl/exp3_fluxo_dados_pkg.sv | 16 +
 rtl/exp3_fluxo_dados_rom_16x4.sv | 13 +
 rtl/exp3_fluxo_dados.sv | 62 ++++++
 tb/tb_exp3_fluxo_dados.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/exp3_fluxo_dados_pkg.sv
// Shared widths and expected-play table for the memory-sequence game datapath.
package exp3_fluxo_dados_pkg;

  localparam int DATA_W    = 4;
  localparam int ADDR_W    = 4;
  localparam int ROM_DEPTH = 16;

  // Entry [i] is the expected play at address i; the list runs from address 15 down to 0.
  localparam logic [ROM_DEPTH-1:0][DATA_W-1:0] ROM_INIT = {
    4'b0100, 4'b0001, 4'b1000, 4'b1000,
    4'b0100, 4'b0100, 4'b0010, 4'b0010,
    4'b0001, 4'b0001, 4'b0010, 4'b0100,
    4'b1000, 4'b0100, 4'b0010, 4'b0001
  };

endpackage

// File: rtl/exp3_fluxo_dados_rom_16x4.sv
// Combinational 16x4 lookup of expected plays.
module rom_16x4
  import exp3_fluxo_dados_pkg::*;
(
  input  logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] saida
);

  always_comb begin
    saida = ROM_INIT[endereco];
  end

endmodule

// File: rtl/exp3_fluxo_dados.sv
// Game datapath: address counter, play register, expected-play ROM and comparator.
// Build option FLUXO_DADOS_CMP_EN adds the menor/maior magnitude outputs.
module exp3_fluxo_dados
  import exp3_fluxo_dados_pkg::*;
(
  input  logic              clock,
  input  logic              zeraC,
  input  logic              zeraR,
  input  logic              contaC,
  input  logic              registraR,
  input  logic [DATA_W-1:0] chaves,
  output logic              igual,
  output logic              fimC,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [DATA_W-1:0] db_jogada,
  output logic [DATA_W-1:0] db_memoria
`ifdef FLUXO_DADOS_CMP_EN
  ,
  output logic              menor,
  output logic              maior
`endif
);

  logic [ADDR_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] jogada_q, jogada_d;
  logic [DATA_W-1:0] rom_word;

  // Clears take priority over their enables; the two paths are independent.
  always_comb begin
    count_d = count_q;
    if (zeraC)       count_d = '0;
    else if (contaC) count_d = count_q + 1'b1;
  end

  always_comb begin
    jogada_d = jogada_q;
    if (zeraR)          jogada_d = '0;
    else if (registraR) jogada_d = chaves;
  end

  always_ff @(posedge clock) begin
    count_q  <= count_d;
    jogada_q <= jogada_d;
  end

  rom_16x4 u_rom (
    .endereco (count_q),
    .saida    (rom_word)
  );

  assign igual       = (jogada_q == rom_word);
  assign fimC        = (count_q == 4'd15);
  assign db_contagem = count_q;
  assign db_jogada   = jogada_q;
  assign db_memoria  = rom_word;

`ifdef FLUXO_DADOS_CMP_EN
  assign menor = (jogada_q < rom_word);
  assign maior = (jogada_q > rom_word);
`endif

endmodule

// File: tb/tb_exp3_fluxo_dados.sv
// Directed self-checking bench for exp3_fluxo_dados.
module tb_exp3_fluxo_dados;

  logic       clock = 1'b0;
  logic       zeraC = 1'b0;
  logic       zeraR = 1'b0;
  logic       contaC = 1'b0;
  logic       registraR = 1'b0;
  logic [3:0] chaves = 4'b0000;
  logic       igual, fimC;
  logic [3:0] db_contagem, db_jogada, db_memoria;
`ifdef FLUXO_DADOS_CMP_EN
  logic       menor, maior;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_rom [16];

  always #5 clock = ~clock;

  exp3_fluxo_dados dut (
    .clock       (clock),
    .zeraC       (zeraC),
    .zeraR       (zeraR),
    .contaC      (contaC),
    .registraR   (registraR),
    .chaves      (chaves),
    .igual       (igual),
    .fimC        (fimC),
    .db_contagem (db_contagem),
    .db_jogada   (db_jogada),
    .db_memoria  (db_memoria)
`ifdef FLUXO_DADOS_CMP_EN
    ,
    .menor       (menor),
    .maior       (maior)
`endif
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, expv);
    end
  endtask

  // Apply current inputs across one rising edge, then sample 1 ns later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_conta();
    contaC = 1'b1;
    step();
    contaC = 1'b0;
  endtask

  task automatic load(input logic [3:0] v);
    chaves = v;
    registraR = 1'b1;
    step();
    registraR = 1'b0;
  endtask

  task automatic check_cmp(input string tag, input logic [3:0] jog, input logic [3:0] mem);
    check({tag, "_igual"}, {3'b000, igual}, {3'b000, jog == mem});
`ifdef FLUXO_DADOS_CMP_EN
    check({tag, "_menor"}, {3'b000, menor}, {3'b000, jog < mem});
    check({tag, "_maior"}, {3'b000, maior}, {3'b000, jog > mem});
`endif
  endtask

  initial begin
    exp_rom = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                4'b0100, 4'b0010, 4'b0001, 4'b0001,
                4'b0010, 4'b0010, 4'b0100, 4'b0100,
                4'b1000, 4'b1000, 4'b0001, 4'b0100};

    @(negedge clock);
    zeraC = 1'b1; zeraR = 1'b1;
    step();
    zeraC = 1'b0; zeraR = 1'b0;
    check("rst_cont", db_contagem, 4'b0000);
    check("rst_jog",  db_jogada,   4'b0000);
    check("rst_mem",  db_memoria,  4'b0001);
    check("rst_igual", {3'b000, igual}, 4'b0000);
    check("rst_fim",   {3'b000, fimC},  4'b0000);

    chaves = 4'b0001;
    step();
    check("noload_jog", db_jogada, 4'b0000);
    check("noload_igual", {3'b000, igual}, 4'b0000);

    load(4'b0001);
    check("load1_jog", db_jogada, 4'b0001);
    check_cmp("load1", 4'b0001, 4'b0001);

    pulse_conta();
    check("a1_cont", db_contagem, 4'b0001);
    check("a1_mem",  db_memoria,  4'b0010);
    check_cmp("a1_old", 4'b0001, 4'b0010);
    load(4'b0010);
    check_cmp("a1_load", 4'b0010, 4'b0010);

    pulse_conta();
    check("a2_mem", db_memoria, 4'b0100);
    load(4'b1000);
    check("a2_jog", db_jogada, 4'b1000);
    check_cmp("a2_load", 4'b1000, 4'b0100);

    step();
    check("hold_cont", db_contagem, 4'b0010);
    check("hold_jog",  db_jogada,   4'b1000);

    for (int a = 3; a <= 15; a++) begin
      pulse_conta();
      check($sformatf("walk%0d_cont", a), db_contagem, 4'(a));
      check($sformatf("walk%0d_mem", a),  db_memoria,  exp_rom[a]);
      check($sformatf("walk%0d_fim", a),  {3'b000, fimC}, {3'b000, a == 15});
      check_cmp($sformatf("walk%0d", a), 4'b1000, exp_rom[a]);
    end

    pulse_conta();
    check("wrap_cont", db_contagem, 4'b0000);
    check("wrap_fim",  {3'b000, fimC}, 4'b0000);
    check("wrap_mem",  db_memoria, 4'b0001);

    pulse_conta();
    check("pri_pre_cont", db_contagem, 4'b0001);
    zeraC = 1'b1; contaC = 1'b1;
    step();
    zeraC = 1'b0; contaC = 1'b0;
    check("pri_zeraC_cont", db_contagem, 4'b0000);
    check("indep_zeraC_jog", db_jogada, 4'b1000);

    zeraR = 1'b1; registraR = 1'b1; chaves = 4'b1111; contaC = 1'b1;
    step();
    zeraR = 1'b0; registraR = 1'b0; contaC = 1'b0;
    check("pri_zeraR_jog", db_jogada, 4'b0000);
    check("indep_zeraR_cont", db_contagem, 4'b0001);
    check_cmp("pri_zeraR", 4'b0000, 4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
